// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - FSM states, segment codes and double-dabble helper for result_display
package result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SHIFT_LAST = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/result_display_bcd_to_seg.sv
// rtl/result_display_bcd_to_seg.sv - combinational BCD nibble to active-low segment decode
module bcd_to_seg
    import result_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Non-decimal codes never reach here from a valid conversion; show them blank
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_DIGIT[i_digit];
        end
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - double-dabble 8-bit to BCD converter with multiplexed 4-digit display
// Optional SIGNED_DISPLAY_EN: treat y as two's complement and show a minus sign on digit 3.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  y,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_work;
    logic [11:0]             r_scratch;
    logic [2:0]              r_iter;
    logic                    r_done;
    logic [11:0]             r_bcd;
    logic                    r_sign_pend;
    logic                    r_neg;
    logic [REFRESH_BITS-1:0] r_scan;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;

    logic                    w_sign;
    logic [7:0]              w_mag;
    logic [11:0]             w_adj;
    logic [REFRESH_BITS-1:0] w_scan_next;
    logic [1:0]              w_k;
    logic [11:0]             w_bcd_view;
    logic                    w_neg_view;
    logic [3:0]              w_nibble;
    logic                    w_force_blank;
    logic                    w_force_minus;
    logic [6:0]              w_dec_seg;
    logic [6:0]              w_seg_next;
    logic [3:0]              w_an_next;

`ifdef SIGNED_DISPLAY_EN
    // -128 negates to 8'h80, which as unsigned magnitude is still 128
    assign w_sign = y[7];
    assign w_mag  = y[7] ? (~y + 8'd1) : y;
`else
    assign w_sign = 1'b0;
    assign w_mag  = y;
`endif

    assign w_adj = dabble_adjust(r_scratch);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_iter == 3'(SHIFT_LAST)) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_scratch   <= '0;
            r_iter      <= '0;
            r_done      <= 1'b0;
            r_bcd       <= '0;
            r_sign_pend <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work      <= w_mag;
                        r_sign_pend <= w_sign;
                    end
                end
                ST_LOAD: begin
                    r_scratch <= '0;
                    r_iter    <= '0;
                end
                ST_SHIFT: begin
                    {r_scratch, r_work} <= {w_adj[10:0], r_work, 1'b0};
                    r_iter              <= r_iter + 3'd1;
                end
                ST_DONE: begin
                    r_bcd  <= r_scratch;
                    r_neg  <= r_sign_pend;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display decodes the value bcd will hold after this edge so seg tracks bcd exactly
    assign w_bcd_view  = (r_state == ST_DONE) ? r_scratch   : r_bcd;
    assign w_neg_view  = (r_state == ST_DONE) ? r_sign_pend : r_neg;
    assign w_scan_next = r_scan + SCAN_ONE;
    assign w_k         = w_scan_next[REFRESH_BITS-1 -: 2];
    assign w_an_next   = ~(4'b0001 << w_k);

    always_comb begin
        w_nibble      = w_bcd_view[3:0];
        w_force_blank = 1'b0;
        w_force_minus = 1'b0;
        case (w_k)
            2'd0: ;
            2'd1: begin
                w_nibble      = w_bcd_view[7:4];
                w_force_blank = (w_bcd_view[11:4] == 8'd0);
            end
            2'd2: begin
                w_nibble      = w_bcd_view[11:8];
                w_force_blank = (w_bcd_view[11:8] == 4'd0);
            end
            default: begin
                w_force_blank = !w_neg_view;
                w_force_minus = w_neg_view;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .i_digit (w_nibble),
        .o_seg   (w_dec_seg)
    );

    assign w_seg_next = w_force_minus ? SEG_MINUS :
                        w_force_blank ? SEG_BLANK : w_dec_seg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan <= '0;
            r_an   <= 4'b1110;
            r_seg  <= SEG_DIGIT[0];
        end else begin
            r_scan <= w_scan_next;
            r_an   <= w_an_next;
            r_seg  <= w_seg_next;
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized self-checking bench for result_display with a behavioural model
module tb_result_display;

    localparam int RB = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  y     = 8'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    result_display #(.REFRESH_BITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .y     (y),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: cycles remaining in a conversion, value shown, and elapsed scan cycles
    int m_left  = 0;
    int m_val   = 0;
    int m_shown = 0;
    int m_cnt   = 0;
    bit m_sign  = 0;
    bit m_neg   = 0;
    bit m_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int k, input int v, input bit neg);
        case (k)
            0:       return seg_tab[v % 10];
            1:       return (v < 10)  ? 7'h7F : seg_tab[(v / 10) % 10];
            2:       return (v < 100) ? 7'h7F : seg_tab[v / 100];
            default: return neg ? 7'h3F : 7'h7F;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left  = 0;
            m_shown = 0;
            m_cnt   = 0;
            m_neg   = 0;
            m_done  = 0;
        end else begin
            m_cnt  = (m_cnt + 1) % (1 << RB);
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    m_left = 10;
`ifdef SIGNED_DISPLAY_EN
                    m_sign = y[7];
                    m_val  = y[7] ? 256 - int'(y) : int'(y);
`else
                    m_sign = 0;
                    m_val  = int'(y);
`endif
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_shown = m_val;
                    m_neg   = m_sign;
                    m_done  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int k;
        k = (m_cnt >> (RB - 2)) & 3;
        check("busy", busy, m_left != 0);
        check("done", done, m_done);
        check("bcd", bcd, to_bcd(m_shown));
        check("an", an, 4'hF ^ (4'b0001 << k));
        check("seg", seg, exp_seg(k, m_shown, m_neg));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [7:0] v);
        y     = v;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (done) begin
                lat = i;
                break;
            end
        end
        check(name, lat, 10);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (done) n++;
        end
    endtask

    initial begin
        int nd;
        tick(3);
        reset = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'h40);

        tick(4);
        check("scan_an1", an, 4'b1101);
        check("scan_seg1", seg, 7'h7F);
        tick(4);
        check("scan_an2", an, 4'b1011);
        tick(4);
        check("scan_an3", an, 4'b0111);
        check("scan_seg3", seg, 7'h7F);
        tick(4);
        check("scan_wrap", an, 4'b1110);

        launch(8'd255);
        wait_done("lat_255");
`ifdef SIGNED_DISPLAY_EN
        check("bcd_255", bcd, 12'h001);
`else
        check("bcd_255", bcd, 12'h255);
`endif

        launch(8'h80);
        wait_done("lat_128");
        check("bcd_128", bcd, 12'h128);

        launch(8'd7);
        tick(3);
        launch(8'd99);
        count_done(20, nd);
        check("ignore_busy_done", nd, 1);
        check("ignore_busy_bcd", bcd, 12'h007);

        launch(8'd200);
        tick(5);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        check("abort_bcd", bcd, 12'h000);
        count_done(15, nd);
        check("abort_nodone", nd, 0);
        launch(8'd200);
        wait_done("lat_200");
`ifdef SIGNED_DISPLAY_EN
        check("bcd_200", bcd, 12'h056);
`else
        check("bcd_200", bcd, 12'h200);
`endif

        launch(8'd0);
        wait_done("lat_0");
        check("bcd_0", bcd, 12'h000);

        for (int i = 0; i < 600; i++) begin
            y     = 8'($urandom);
            start = ($urandom % 4) == 0;
            if (($urandom % 150) == 0) begin
                reset = 1'b0;
                tick(1);
                reset = 1'b1;
            end else begin
                tick(1);
            end
        end
        start = 1'b0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 17, width of the free-running digit-scan counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port y  input  8  ALU result to display.
REQ-005 SHALL have port start  input  1  request to convert y; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when new digits are latched.
REQ-008 SHALL have port bcd  output  12  latched {hundreds, tens, ones}, 4 bits each.
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port an  output  4  active-low digit enables; an[0] is the ones digit.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-012 IDLE -> LOAD when start=1; y is captured into an 8-bit work register on that edge.
REQ-013 LOAD SHALL clear the 12-bit BCD scratch register and the 3-bit iteration counter, then go to SHIFT.
REQ-014 SHIFT SHALL run the double-dabble algorithm.
REQ-015 Each SHIFT cycle SHALL add 3 to every scratch nibble >= 5, then shift {scratch, work} left by 1.
REQ-016 SHIFT SHALL run for exactly 8 cycles, then go to DONE.
REQ-017 DONE SHALL copy scratch to bcd, assert done for that single cycle, and return to IDLE.
REQ-018 Latency: start sampled at edge N gives done=1 and the new bcd in the cycle following edge N+10.
REQ-019 busy SHALL be high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 bcd and the display SHALL hold their previous value until DONE.
REQ-022 The scan counter SHALL be free-running and wrap at 2^REFRESH_BITS.
REQ-023 The top 2 bits of the scan counter select digit k = 0..3; an = ~(4'b0001 << k).
REQ-024 Digit 0 SHALL always show the ones value.
REQ-025 Digits 1 and 2 SHALL show tens and hundreds, blanked (seg=7'h7F) when they and all higher digits are zero.
REQ-026 Digit 3 SHALL be blank unless REQ-030 applies.
REQ-027 seg SHALL be registered, aligned with an in the same cycle.

Reset
REQ-028 On reset low, asynchronously, the block SHALL force:
- FSM to IDLE;
- busy=0, done=0, bcd=0;
- scan counter to 0, an=4'b1110, seg showing "0" (7'h40).
REQ-029 Reset asserted mid-conversion SHALL abort it.
- bcd SHALL stay 0.
- No done pulse SHALL follow.

Configuration
REQ-030 With SIGNED_DISPLAY_EN defined, the block SHALL treat y as two's complement.
- LOAD captures |y|; sign is latched at DONE.
- Digit 3 shows minus (seg=7'h3F) when the sign is negative.
- -128 SHALL display as 128.
REQ-031 Without SIGNED_DISPLAY_EN, y SHALL be unsigned 0..255, and digit 3 is always blank.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enum;
- the segment constants SEG_BLANK, SEG_MINUS and SEG_DIGIT[0:9].
REQ-033 One sub-module, bcd_to_seg, SHALL perform the combinational nibble-to-segment decode.
REQ-034 The FSM, datapath and scan logic SHALL stay in result_display.

Verification
REQ-035 y=8'd255, start pulse: bcd=12'h255 and done high in the cycle after edge N+10; busy high for 3 to 10 cycles.
REQ-036 y=8'd0, start: bcd=0; scanning shows "0" only on an[0], with digits 1-3 blank.
REQ-037 start again 4 cycles after a first start with y=8'd7: bcd=7 from the first request only, and exactly one done pulse.
REQ-038 Reset low at SHIFT iteration 4 of y=8'd200: bcd=0 and no done pulse; a later start gives bcd=12'h200.
REQ-039 SIGNED_DISPLAY_EN defined:
- y=8'hFF shows "-  1", i.e. minus on digit 3, blanks on digits 2-1, ones 1;
- y=8'h80 shows "-128".
REQ-040 REFRESH_BITS=4: an SHALL step 1110 -> 1101 -> 1011 -> 0111 every 4 clocks and wrap.
